mem_datos_lsu: RTL

// - Load/store initiator placed between the datapath and Memoria_Datos (word-wide, single we, no byte enables).
// - Accepts byte-addressed load/store requests with a valid/ready handshake and drives the memory's we/Addrs/Data lines.
// - Formats read data (lane select, sign/zero extension) and performs read-modify-write for byte/half stores.
// - Returns one response per request and flags misaligned, illegal-size and out-of-range accesses.

---
 rtl/mem_datos_lsu.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_datos_lsu.sv
// Load/store unit in front of Memoria_Datos: accepts byte-addressed requests,
// drives the word-wide memory, extracts and extends load lanes, and merges
// sub-word stores by reading the word, patching the lane and writing it back.
//
// state | meaning
// IDLE  | ready for a request
// ACC   | word address on the bus; word stores write here
// WAIT  | memory read data available; format load or build merged word
// WR    | write back merged word for byte/half store
// RESP  | one-cycle response strobe
module mem_datos_lsu #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [DW-1:0] rsp_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACC, WAIT, WR, RESP} state_t;

  state_t        state, state_nxt;
  logic          lat_we, lat_we_nxt;
  logic [1:0]    lat_size, lat_size_nxt;
  logic          lat_uns, lat_uns_nxt;
  logic [1:0]    lat_lane, lat_lane_nxt;
  logic [15:0]   lat_wdata, lat_wdata_nxt;
  logic          mem_we_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          rsp_err_nxt;
  logic [DW-1:0] rsp_rdata_nxt;

  logic          req_err;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [DW-1:0] load_fmt;
  logic [DW-1:0] merged;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Reject illegal size, misalignment and addresses beyond the memory
  assign req_err = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || (req_addr[31:AW+2] != '0);

  // Lane extraction, extension and sub-word merge from the read word
  always_comb begin
    case (lat_lane)
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      2'd3:    rd_byte = mem_rdata[31:24];
      default: rd_byte = mem_rdata[7:0];
    endcase
    rd_half = lat_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt = mem_rdata;
    case (lat_size)
      2'b00:   load_fmt = {{24{rd_byte[7] & ~lat_uns}}, rd_byte};
      2'b01:   load_fmt = {{16{rd_half[15] & ~lat_uns}}, rd_half};
      default: load_fmt = mem_rdata;
    endcase
    merged = mem_rdata;
    if (lat_size == 2'b00) begin
      case (lat_lane)
        2'd1:    merged[15:8]  = lat_wdata[7:0];
        2'd2:    merged[23:16] = lat_wdata[7:0];
        2'd3:    merged[31:24] = lat_wdata[7:0];
        default: merged[7:0]   = lat_wdata[7:0];
      endcase
    end else if (lat_lane[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  // Next-state and next-output decode; outputs only change on transitions
  always_comb begin
    state_nxt     = state;
    lat_we_nxt    = lat_we;
    lat_size_nxt  = lat_size;
    lat_uns_nxt   = lat_uns;
    lat_lane_nxt  = lat_lane;
    lat_wdata_nxt = lat_wdata;
    mem_we_nxt    = 1'b0;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    rsp_err_nxt   = rsp_err;
    rsp_rdata_nxt = rsp_rdata;
    case (state)
      IDLE: begin
        if (req_valid) begin
          lat_we_nxt    = req_we;
          lat_size_nxt  = req_size;
          lat_uns_nxt   = req_unsigned;
          lat_lane_nxt  = req_addr[1:0];
          lat_wdata_nxt = req_wdata[15:0];
          if (req_err) begin
            state_nxt     = RESP;
            rsp_err_nxt   = 1'b1;
            rsp_rdata_nxt = '0;
          end else begin
            state_nxt    = ACC;
            mem_addr_nxt = req_addr[AW+1:2];
            if (req_we && (req_size == 2'b10)) begin
              mem_we_nxt    = 1'b1;
              mem_wdata_nxt = req_wdata;
            end
          end
        end
      end
      ACC: begin
        if (lat_we && (lat_size == 2'b10)) begin
          state_nxt     = RESP;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = '0;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (!lat_we) begin
          state_nxt     = RESP;
          rsp_err_nxt   = 1'b0;
          rsp_rdata_nxt = load_fmt;
        end else begin
          state_nxt     = WR;
          mem_we_nxt    = 1'b1;
          mem_wdata_nxt = merged;
        end
      end
      WR: begin
        state_nxt     = RESP;
        rsp_err_nxt   = 1'b0;
        rsp_rdata_nxt = '0;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_we    <= 1'b0;
      lat_size  <= 2'b00;
      lat_uns   <= 1'b0;
      lat_lane  <= 2'b00;
      lat_wdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      lat_we    <= lat_we_nxt;
      lat_size  <= lat_size_nxt;
      lat_uns   <= lat_uns_nxt;
      lat_lane  <= lat_lane_nxt;
      lat_wdata <= lat_wdata_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      rsp_err   <= rsp_err_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

endmodule
